// File: rtl/qc_rng_pkg.sv
// Shared constants and types for the quantum-controller random source.
package qc_rng_pkg;

    localparam int unsigned Q_FRAC_W        = 16;
    localparam logic [31:0] Q_ONE           = 32'h0001_0000;
    localparam logic [31:0] QC_DEFAULT_TAPS = 32'h8020_0003;
    localparam logic [31:0] QC_DEFAULT_SEED = 32'hDEAD_BEEF;
    localparam int unsigned WARM_W          = 16;

    typedef enum logic {
        ST_WARMUP = 1'b0,
        ST_RUN    = 1'b1
    } rng_state_e;

endpackage

// File: rtl/lfsr_step.sv
// One Fibonacci LFSR step: feedback is the XOR of tapped bits, shifted in at bit 0.
module lfsr_step #(
    parameter int unsigned         LFSR_W = 32,
    parameter logic [LFSR_W-1:0]   TAPS   = LFSR_W'(32'h8020_0003)
) (
    input  logic [LFSR_W-1:0] state,
    output logic [LFSR_W-1:0] next_c
);

    logic fb;

    always_comb begin
        fb     = ^(state & TAPS);
        next_c = {state[LFSR_W-2:0], fb};
    end

endmodule

// File: rtl/lfsr_rng_stream.sv
// Seedable LFSR sample stream with valid/ready output and a registered measurement outcome.
module lfsr_rng_stream
    import qc_rng_pkg::*;
#(
    parameter int unsigned       LFSR_W       = 32,
    parameter logic [LFSR_W-1:0] TAPS         = LFSR_W'(QC_DEFAULT_TAPS),
    parameter logic [LFSR_W-1:0] DEFAULT_SEED = LFSR_W'(QC_DEFAULT_SEED),
    parameter int unsigned       FRAC_W       = 16,
    parameter int unsigned       WARMUP       = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed_in,
    input  logic [31:0]       prob_q,
    output logic              rnd_valid,
    input  logic              rnd_ready,
    output logic [31:0]       rnd_out,
    output logic              meas_bit,
    output logic              busy,
    output logic [31:0]       sample_cnt
);

    // Fraction bits actually available when the LFSR is narrower than FRAC_W.
    localparam int unsigned FW          = (FRAC_W < LFSR_W) ? FRAC_W : LFSR_W;
    localparam rng_state_e  INIT_FSM    = (WARMUP > 0) ? ST_WARMUP : ST_RUN;
    localparam logic        INIT_BUSY   = (WARMUP > 0);
    localparam logic [WARM_W-1:0] INIT_WARM = WARM_W'(WARMUP);

    rng_state_e        fsm;
    logic [LFSR_W-1:0] state;
    logic [LFSR_W-1:0] next_c;
    logic [WARM_W-1:0] warm_cnt;
    logic [15:0]       frac_c;
    logic              meas_c;
    logic              produce_c;
    logic              accept_c;
    logic              state_zero_c;

    lfsr_step #(
        .LFSR_W (LFSR_W),
        .TAPS   (TAPS)
    ) u_step (
        .state  (state),
        .next_c (next_c)
    );

    // Sample formatting and handshake qualifiers.
    always_comb begin
        frac_c       = 16'(next_c[FW-1:0]) << (Q_FRAC_W - FW);
        meas_c       = !prob_q[31] && ((prob_q >= Q_ONE) || ({16'd0, frac_c} < prob_q));
        accept_c     = rnd_valid && rnd_ready;
        produce_c    = enable && (!rnd_valid || rnd_ready);
        state_zero_c = (state == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= DEFAULT_SEED;
            fsm        <= INIT_FSM;
            busy       <= INIT_BUSY;
            warm_cnt   <= INIT_WARM;
            rnd_valid  <= 1'b0;
            rnd_out    <= 32'd0;
            meas_bit   <= 1'b0;
            sample_cnt <= 32'd0;
        end else if (seed_load) begin
            // Pending sample is dropped and deliberately not counted.
            state     <= (seed_in == '0) ? DEFAULT_SEED : seed_in;
            fsm       <= INIT_FSM;
            busy      <= INIT_BUSY;
            warm_cnt  <= INIT_WARM;
            rnd_valid <= 1'b0;
        end else begin
            if (accept_c) begin
                sample_cnt <= sample_cnt + 32'd1;
            end
            if (state_zero_c) begin
                state <= DEFAULT_SEED;
                if (accept_c) begin
                    rnd_valid <= 1'b0;
                end
            end else begin
                case (fsm)
                    ST_WARMUP: begin
                        state <= next_c;
                        if (warm_cnt <= WARM_W'(1)) begin
                            fsm  <= ST_RUN;
                            busy <= 1'b0;
                        end else begin
                            warm_cnt <= warm_cnt - WARM_W'(1);
                        end
                    end
                    ST_RUN: begin
                        if (produce_c) begin
                            state     <= next_c;
                            rnd_out   <= {16'd0, frac_c};
                            meas_bit  <= meas_c;
                            rnd_valid <= 1'b1;
                        end else if (accept_c) begin
                            rnd_valid <= 1'b0;
                        end
                    end
                    default: begin
                        fsm <= ST_RUN;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lfsr_rng_stream.sv
// Directed self-checking bench: default stream, backpressure, reseed, meas corners, warm-up, async reset.
module tb_lfsr_rng_stream;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        seed_load;
    logic        w_seed_load;
    logic [31:0] seed_in;
    logic [31:0] prob_q;
    logic        rnd_ready;

    logic        rnd_valid, meas_bit, busy;
    logic [31:0] rnd_out, sample_cnt;
    logic        w_rnd_valid, w_meas_bit, w_busy;
    logic [31:0] w_rnd_out, w_sample_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lfsr_rng_stream dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .seed_load  (seed_load),
        .seed_in    (seed_in),
        .prob_q     (prob_q),
        .rnd_valid  (rnd_valid),
        .rnd_ready  (rnd_ready),
        .rnd_out    (rnd_out),
        .meas_bit   (meas_bit),
        .busy       (busy),
        .sample_cnt (sample_cnt)
    );

    lfsr_rng_stream #(.WARMUP(3)) dut_w (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .seed_load  (w_seed_load),
        .seed_in    (seed_in),
        .prob_q     (prob_q),
        .rnd_valid  (w_rnd_valid),
        .rnd_ready  (rnd_ready),
        .rnd_out    (w_rnd_out),
        .meas_bit   (w_meas_bit),
        .busy       (w_busy),
        .sample_cnt (w_sample_cnt)
    );

    // Reference step with the default taps 32,22,2,1 written out bit by bit.
    function automatic logic [31:0] ref_step(input logic [31:0] s);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_main(input string tag, input logic v, input logic [31:0] o,
                            input logic m, input logic [31:0] c);
        chk({tag, ".valid"}, 32'(rnd_valid), 32'(v));
        chk({tag, ".out"},   rnd_out, o);
        chk({tag, ".meas"},  32'(meas_bit), 32'(m));
        chk({tag, ".cnt"},   sample_cnt, c);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] ref_s;

        reset       = 1'b1;
        enable      = 1'b1;
        rnd_ready   = 1'b1;
        seed_load   = 1'b0;
        w_seed_load = 1'b0;
        seed_in     = 32'd0;
        prob_q      = 32'd0;

        ref_s = 32'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) ref_s = ref_step(ref_s);

        tick;
        tick;
        chk_main("reset", 1'b0, 32'd0, 1'b0, 32'd0);
        chk("reset.busy", 32'(busy), 32'd0);
        chk("reset.w_busy", 32'(w_busy), 32'd1);

        reset = 1'b0;
        tick;
        chk_main("first", 1'b1, 32'h0000_7DDE, 1'b0, 32'd0);
        chk("first.w_busy", 32'(w_busy), 32'd1);
        chk("first.w_valid", 32'(w_rnd_valid), 32'd0);

        // Backpressure with a changing probability and a dip in enable.
        rnd_ready = 1'b0;
        prob_q    = 32'h0000_7DDF;
        for (int i = 0; i < 5; i++) begin
            tick;
            chk_main("hold", 1'b1, 32'h0000_7DDE, 1'b0, 32'd0);
            if (i == 0) begin
                chk("warm2.busy", 32'(w_busy), 32'd1);
                chk("warm2.valid", 32'(w_rnd_valid), 32'd0);
            end
            if (i == 1) begin
                chk("warm3.busy", 32'(w_busy), 32'd0);
                chk("warm3.valid", 32'(w_rnd_valid), 32'd0);
            end
            if (i == 2) begin
                chk("warm_first.valid", 32'(w_rnd_valid), 32'd1);
                chk("warm_first.out", w_rnd_out, {16'd0, ref_s[15:0]});
                chk("warm_first.out_hand", w_rnd_out, 32'h0000_EEF3);
                enable = 1'b0;
            end
            if (i == 3) enable = 1'b1;
        end

        rnd_ready = 1'b1;
        prob_q    = 32'h0001_0000;
        tick;
        chk_main("accept", 1'b1, 32'h0000_FBBC, 1'b1, 32'd1);

        // Zero seed load discards the pending sample.
        rnd_ready = 1'b0;
        seed_load = 1'b1;
        seed_in   = 32'd0;
        prob_q    = 32'h0000_7DDF;
        tick;
        chk("seed0.valid", 32'(rnd_valid), 32'd0);
        chk("seed0.cnt", sample_cnt, 32'd1);
        seed_load = 1'b0;
        tick;
        chk_main("reseed", 1'b1, 32'h0000_7DDE, 1'b1, 32'd1);

        rnd_ready = 1'b1;
        prob_q    = 32'h8000_0000;
        tick;
        chk_main("neg_prob", 1'b1, 32'h0000_FBBC, 1'b0, 32'd2);

        // Seed load while the consumer is ready: still not counted.
        seed_load = 1'b1;
        tick;
        chk("seed_rdy.valid", 32'(rnd_valid), 32'd0);
        chk("seed_rdy.cnt", sample_cnt, 32'd2);
        seed_load = 1'b0;
        prob_q    = 32'h0000_7DDE;
        tick;
        chk_main("eq_prob", 1'b1, 32'h0000_7DDE, 1'b0, 32'd2);

        // Asynchronous reset mid-stream.
        #2;
        reset = 1'b1;
        #1;
        chk_main("async_rst", 1'b0, 32'd0, 1'b0, 32'd0);
        chk("async_rst.busy", 32'(busy), 32'd0);
        chk("async_rst.w_busy", 32'(w_busy), 32'd1);
        tick;
        reset = 1'b0;
        tick;
        chk_main("post_rst1", 1'b1, 32'h0000_7DDE, 1'b0, 32'd0);
        tick;
        chk_main("post_rst2", 1'b1, 32'h0000_FBBC, 1'b0, 32'd1);

        // Nonzero seed: 1 -> 3 -> 6.
        seed_load = 1'b1;
        seed_in   = 32'h0000_0001;
        tick;
        chk("seed1.valid", 32'(rnd_valid), 32'd0);
        chk("seed1.cnt", sample_cnt, 32'd1);
        seed_load = 1'b0;
        tick;
        chk_main("seed1.s1", 1'b1, 32'h0000_0003, 1'b1, 32'd1);
        tick;
        chk_main("seed1.s2", 1'b1, 32'h0000_0006, 1'b1, 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
